// File: rtl/sd_block_responder_pkg.sv
// Shared types and constants for the SD block responder.
// Holds the FSM state type, sector geometry and holdoff length.
package iigs_sd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RD_FETCH,
        S_RD_PUSH,
        S_WR_ADDR,
        S_WR_STORE,
        S_RELEASE,
        S_HOLDOFF
    } sd_state_t;

    localparam int SECTOR_BYTES   = 512;
    localparam int SECTOR_SHIFT   = 9;
    localparam int HOLDOFF_CYCLES = 2;

    localparam logic [SECTOR_SHIFT-1:0] LAST_BYTE =
        SECTOR_SHIFT'(SECTOR_BYTES - 1);

    // States in which the granted drive sees sd_ack high.
    function automatic logic in_xfer(sd_state_t s);
        return s inside {S_RD_FETCH, S_RD_PUSH, S_WR_ADDR, S_WR_STORE};
    endfunction

endpackage

// File: rtl/sd_block_responder_if.sv
// Sector block bus between requesters, responder and backing memory.
// slave: responder side; master: requester/memory side.
interface sd_block_responder_if #(
    parameter int VDNUM  = 3,
    parameter int ADDR_W = 27
);
    logic [32*VDNUM-1:0]     sd_lba;
    logic [VDNUM-1:0]        sd_rd;
    logic [VDNUM-1:0]        sd_wr;
    logic [VDNUM-1:0]        sd_ack;
    logic [8:0]              sd_buff_addr;
    logic [7:0]              sd_buff_dout;
    logic                    sd_buff_wr;
    logic [8*VDNUM-1:0]      sd_buff_din;
    logic [ADDR_W*VDNUM-1:0] img_base;
    logic [32*VDNUM-1:0]     img_sectors;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [7:0]              mem_wdata;
    logic [7:0]              mem_rdata;
    logic                    mem_ready;

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  img_base, img_sectors, mem_rdata, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        output img_base, img_sectors, mem_rdata, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );

endinterface

// File: rtl/sd_block_responder_arb.sv
// Fixed-priority request encoder, lowest index wins.
// req_i: requests; valid_o/idx_o/onehot_o: winning drive.
module sd_req_arb #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    // Scan from the top so the lowest active index is written last.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o  = 1'b1;
                idx_o    = IDX_W'(i);
                onehot_o = N'(1) << i;
            end
        end
    end

endmodule

// File: rtl/sd_block_responder.sv
// Device end of the per-drive sector protocol, served from byte memory.
// Ports: clk_sys, reset_n, bus (slave modport), busy, oob.
module sd_block_responder
    import iigs_sd_pkg::*;
#(
    parameter int VDNUM  = 3,
    parameter int ADDR_W = 27
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    sd_block_responder_if.slave bus,
    output logic                busy,
    output logic                oob
);

    localparam int IDX_W = (VDNUM > 1) ? $clog2(VDNUM) : 1;

    sd_state_t               state_q, state_d;
    logic [IDX_W-1:0]        drv_q, drv_d;
    logic [VDNUM-1:0]        sel_q, sel_d;
    logic [VDNUM-1:0]        ack_q, ack_d;
    logic [31:0]             lba_q, lba_d;
    logic                    rd_q, rd_d;
    logic                    oob_q, oob_d;
    logic [SECTOR_SHIFT-1:0] k_q, k_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [7:0]              data_q, data_d;
    logic [1:0]              hold_q, hold_d;

    logic             req_v;
    logic [IDX_W-1:0] req_idx;
    logic [VDNUM-1:0] req_oh;

    sd_req_arb #(
        .N     (VDNUM),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i    (bus.sd_rd | bus.sd_wr),
        .valid_o  (req_v),
        .idx_o    (req_idx),
        .onehot_o (req_oh)
    );

    logic [31:0]       sel_sectors;
    logic [ADDR_W-1:0] sel_base;
    logic [7:0]        sel_din;
    logic              lba_oob;
    logic              mem_go;

    assign sel_sectors = bus.img_sectors[32*drv_q +: 32];
    assign sel_base    = bus.img_base[ADDR_W*drv_q +: ADDR_W];
    assign sel_din     = bus.sd_buff_din[8*drv_q +: 8];
    assign lba_oob     = (lba_q >= sel_sectors);

    assign mem_go = !oob_q &&
        (state_q == S_RD_FETCH || state_q == S_WR_STORE);

    // Outputs decode from reset registers, so reset clears them at once.
    assign bus.sd_ack       = ack_q;
    assign bus.sd_buff_wr   = (state_q == S_RD_PUSH);
    assign bus.sd_buff_dout = data_q;
    assign bus.sd_buff_addr = in_xfer(state_q) ? k_q : '0;
    assign bus.mem_rd       = mem_go && (state_q == S_RD_FETCH);
    assign bus.mem_wr       = mem_go && (state_q == S_WR_STORE);
    assign bus.mem_addr     = mem_go ? base_q + ADDR_W'(k_q) : '0;
    assign bus.mem_wdata    = (state_q == S_WR_STORE) ? sel_din : '0;
    assign busy             = (state_q != S_IDLE);
    assign oob              = (state_q == S_GRANT) && lba_oob;

    always_comb begin
        state_d = state_q;
        drv_d   = drv_q;
        sel_d   = sel_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        oob_d   = oob_q;
        k_d     = k_q;
        base_d  = base_q;
        data_d  = data_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_v) begin
                    drv_d   = req_idx;
                    sel_d   = req_oh;
                    lba_d   = bus.sd_lba[32*req_idx +: 32];
                    rd_d    = bus.sd_rd[req_idx];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                k_d     = '0;
                oob_d   = lba_oob;
                base_d  = sel_base +
                    (ADDR_W'(lba_q) << SECTOR_SHIFT);
                state_d = rd_q ? S_RD_FETCH : S_WR_ADDR;
            end
            S_RD_FETCH: begin
                if (oob_q) begin
                    data_d  = 8'h00;
                    state_d = S_RD_PUSH;
                end else if (bus.mem_ready) begin
                    data_d  = bus.mem_rdata;
                    state_d = S_RD_PUSH;
                end
            end
            S_RD_PUSH: begin
                if (k_q == LAST_BYTE) begin
                    state_d = S_RELEASE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_RD_FETCH;
                end
            end
            // One cycle for the requester's registered buffer read.
            S_WR_ADDR: state_d = S_WR_STORE;
            S_WR_STORE: begin
                if (oob_q || bus.mem_ready) begin
                    if (k_q == LAST_BYTE) begin
                        state_d = S_RELEASE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_RELEASE: begin
                hold_d  = '0;
                state_d = S_HOLDOFF;
            end
            // Lets requesters that clear on ack-rise drop the level.
            S_HOLDOFF: begin
                if (hold_q == 2'(HOLDOFF_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ack_d = in_xfer(state_d) ? sel_q : '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            drv_q   <= '0;
            sel_q   <= '0;
            ack_q   <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            oob_q   <= 1'b0;
            k_q     <= '0;
            base_q  <= '0;
            data_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            oob_q   <= oob_d;
            k_q     <= k_d;
            base_q  <= base_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
        end
    end

endmodule
